// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target: req/ack handshake with programmable wait states,
// little-endian byte/half/word lanes, load extension and alignment/range error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        ren,
    input  logic        wen,
    input  logic [1:0]  rwtype,
    input  logic        sign_extend,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        addr_err
);
    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW   = 4;
    localparam logic [32:0] SPAN = 33'(64'(DEPTH_WORDS) * 64'd4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           ren_q, wen_q, sext_q;
    logic [1:0]     rwtype_q;
    logic [31:0]    addr_q, wdata_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept_c;
    logic [31:0]    off_c;
    logic [AW-1:0]  idx_c;
    logic           err_c;
    logic [4:0]     lane_sh_c;
    logic [31:0]    shifted_c, load_c, mask_c, store_c;
    logic           mem_we_c;
    logic           busy_d, ack_d, err_d;
    logic [31:0]    rdata_d;

    assign accept_c  = req && (ren || wen);
    assign off_c     = addr_q - BASE_ADDR;
    assign idx_c     = AW'(off_c >> 2);
    assign lane_sh_c = {addr_q[1:0], 3'b000};
    assign shifted_c = mem[idx_c] >> lane_sh_c;

    // Rejected requests: misalignment, reserved size, ambiguous direction, out of range
    always_comb begin
        err_c = 1'b0;
        if (rwtype_q == 2'b11)                         err_c = 1'b1;
        if (ren_q && wen_q)                            err_c = 1'b1;
        if (rwtype_q == 2'b01 && addr_q[0])            err_c = 1'b1;
        if (rwtype_q == 2'b10 && addr_q[1:0] != 2'b00) err_c = 1'b1;
        if (addr_q < BASE_ADDR)                        err_c = 1'b1;
        if ({1'b0, off_c} >= SPAN)                     err_c = 1'b1;
    end

    // Lane extraction/extension for loads and lane merge for stores
    always_comb begin
        load_c = shifted_c;
        mask_c = 32'hFFFF_FFFF;
        case (rwtype_q)
            2'b00: begin
                load_c = {{24{sext_q & shifted_c[7]}}, shifted_c[7:0]};
                mask_c = 32'h0000_00FF << lane_sh_c;
            end
            2'b01: begin
                load_c = {{16{sext_q & shifted_c[15]}}, shifted_c[15:0]};
                mask_c = 32'h0000_FFFF << lane_sh_c;
            end
            default: ;
        endcase
        store_c = (mem[idx_c] & ~mask_c) | ((wdata_q << lane_sh_c) & mask_c);
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        mem_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    ack_d    = 1'b1;
                    err_d    = err_c;
                    mem_we_c = wen_q && !err_c;
                    rdata_d  = (ren_q && !err_c) ? load_c : '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy     <= 1'b0;
            ack      <= 1'b0;
            rdata    <= '0;
            addr_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= busy_d;
            ack      <= ack_d;
            rdata    <= rdata_d;
            addr_err <= err_d;
        end
    end

    // Captured request and wait-state counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            sext_q   <= 1'b0;
            rwtype_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state_q == S_IDLE && accept_c) begin
            cnt_q    <= CW'(WAIT_CYCLES);
            ren_q    <= ren;
            wen_q    <= wen;
            sext_q   <= sign_extend;
            rwtype_q <= rwtype;
            addr_q   <= addr;
            wdata_q  <= wdata;
        end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage is not reset; the write commits on the edge entering RESP
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[idx_c] <= store_c;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, hand-written
// corner sequences, and random traffic against a byte-array reference model.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WAITS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_b, ren, wen, sign_extend;
    logic [1:0]  rwtype;
    logic [31:0] addr, wdata;
    logic        busy, ack, addr_err;
    logic [31:0] rdata;
    logic        busy_b, ack_b, addr_err_b;
    logic [31:0] rdata_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mbytes [4*DEPTH];

    typedef struct {
        logic        r;
        logic        w;
        logic [1:0]  t;
        logic        s;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req(req), .ren(ren), .wen(wen), .rwtype(rwtype),
        .sign_extend(sign_extend), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .addr_err(addr_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_w0 (
        .clk(clk), .rst(rst), .req(req_b), .ren(ren), .wen(wen), .rwtype(rwtype),
        .sign_extend(sign_extend), .addr(addr), .wdata(wdata),
        .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .addr_err(addr_err_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array
    task automatic model_op(input logic r, input logic w, input logic [1:0] t, input logic s,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic e, output logic [31:0] rd);
        longint ua;
        int n;
        int off;
        ua = longint'(a);
        n  = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        e  = (t == 2'd3) || (r && w) || (t == 2'd1 && a[0]) ||
             (t == 2'd2 && a[1:0] != 2'b00) || (ua < longint'(BASE)) ||
             (ua >= longint'(BASE) + 4 * longint'(DEPTH));
        rd = '0;
        if (!e) begin
            off = int'(ua - longint'(BASE));
            if (w) begin
                for (int k = 0; k < n; k++) mbytes[off + k] = d[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) rd[8*k +: 8] = mbytes[off + k];
                if (s && n < 4 && rd[8*n - 1])
                    for (int k = 8 * n; k < 32; k++) rd[k] = 1'b1;
            end
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance; inputs are scrambled after acceptance
    task automatic run_op(input logic r, input logic w, input logic [1:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int bsy, output logic ack_after);
        @(negedge clk);
        req = 1'b1; ren = r; wen = w; rwtype = t; sign_extend = s; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; ren = 1'($urandom); wen = 1'($urandom); rwtype = 2'($urandom);
        sign_extend = 1'($urandom); addr = $urandom; wdata = $urandom;
        lat = 0; bsy = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) bsy++;
            if (ack) begin
                lat = i; rd = rdata; er = addr_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (busy) bsy++;
        ack_after = ack;
    endtask

    task automatic directed(input string tag, input vec_t v);
        logic [31:0] rd;
        logic er, ack_after, me;
        logic [31:0] mrd;
        int lat, bsy;
        model_op(v.r, v.w, v.t, v.s, v.a, v.d, me, mrd);
        run_op(v.r, v.w, v.t, v.s, v.a, v.d, rd, er, lat, bsy, ack_after);
        check({tag, " rdata"}, rd, v.rd);
        check({tag, " addr_err"}, 32'(er), 32'(v.e));
        check({tag, " latency"}, 32'(lat), 32'(WAITS + 2));
        check({tag, " busy_cycles"}, 32'(bsy), 32'(WAITS + 2));
        check({tag, " ack_pulse"}, 32'(ack_after), 32'd0);
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [1:0] t, input logic s,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic e, input logic [31:0] rd);
        vec_t v;
        v.r = r; v.w = w; v.t = t; v.s = s; v.a = a; v.d = d; v.e = e; v.rd = rd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mrd, a;
        logic er, me, ack_after;
        logic r, w, s;
        logic [1:0] t;
        int lat, bsy, cnt, prev, nacks, gap_bad, nbusy, nerr;
        logic found;

        // Directed vectors: {ren, wen, rwtype, sign_extend, addr, wdata, exp_err, exp_rdata}
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h10, 32'h1234_5678, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h20, 32'hAABB_CCDD, 0, 32'h0));
        vecs.push_back(mk(0, 1, 2'd0, 0, 32'h21, 32'h1234_5680, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 32'hAABB_80DD));
        vecs.push_back(mk(1, 0, 2'd0, 1, 32'h21, 32'h0, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 0, 2'd0, 0, 32'h21, 32'h0, 0, 32'h0000_0080));
        vecs.push_back(mk(1, 0, 2'd0, 1, 32'h23, 32'h0, 0, 32'hFFFF_FFAA));
        vecs.push_back(mk(1, 0, 2'd1, 0, 32'h20, 32'h0, 0, 32'h0000_80DD));
        vecs.push_back(mk(1, 0, 2'd2, 1, 32'h20, 32'h0, 0, 32'hAABB_80DD));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h30, 32'h5555_AAAA, 0, 32'h0));
        vecs.push_back(mk(0, 1, 2'd1, 0, 32'h32, 32'hDEAD_8001, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd1, 1, 32'h32, 32'h0, 0, 32'hFFFF_8001));
        vecs.push_back(mk(1, 0, 2'd1, 0, 32'h32, 32'h0, 0, 32'h0000_8001));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h30, 32'h0, 0, 32'h8001_AAAA));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h13, 32'h0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 2'd1, 0, 32'h31, 32'h0000_FFFF, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h30, 32'h0, 0, 32'h8001_AAAA));
        vecs.push_back(mk(1, 1, 2'd2, 0, 32'h30, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h1000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'd3, 0, 32'h30, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'hFFC, 32'h0BAD_BEEF, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'hFFC, 32'h0, 0, 32'h0BAD_BEEF));

        rst = 1'b1; req = 1'b0; req_b = 1'b0; ren = 1'b0; wen = 1'b0;
        rwtype = 2'd0; sign_extend = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0;

        // Known contents for the random window (bytes 0x00..0x3F)
        for (int i = 0; i < 16; i++) begin
            a = 32'(4 * i);
            wdata = $urandom;
            mrd = wdata;
            model_op(1'b0, 1'b1, 2'd2, 1'b0, a, mrd, me, rd);
            run_op(1'b0, 1'b1, 2'd2, 1'b0, a, mrd, rd, er, lat, bsy, ack_after);
            check($sformatf("preload%0d addr_err", i), 32'(er), 32'd0);
        end

        foreach (vecs[i]) directed($sformatf("vec%0d", i), vecs[i]);

        // Reset during WAIT aborts the store
        directed("preload_cafe", mk(0, 1, 2'd2, 0, 32'h40, 32'hCAFE_F00D, 0, 32'h0));
        @(negedge clk);
        req = 1'b1; ren = 1'b0; wen = 1'b1; rwtype = 2'd2; addr = 32'h40; wdata = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("pre_reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack || busy) cnt++;
        end
        check("reset_mid_wait activity", 32'(cnt), 32'd0);
        rst = 1'b0;
        directed("post_reset_read", mk(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 32'hCAFE_F00D));

        // req with neither ren nor wen is ignored
        @(negedge clk);
        req = 1'b1; ren = 1'b0; wen = 1'b0; rwtype = 2'd2; addr = 32'h10;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || ack) cnt++;
        end
        req = 1'b0;
        check("ignored_req activity", 32'(cnt), 32'd0);

        // WAIT_CYCLES=0 instance: req held high gives an ack every third cycle
        @(negedge clk);
        req_b = 1'b1; ren = 1'b0; wen = 1'b1; rwtype = 2'd2; addr = 32'h50; wdata = 32'h0000_0077;
        prev = -1; nacks = 0; gap_bad = 0; nbusy = 0; nerr = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy_b) nbusy++;
            if (addr_err_b) nerr++;
            if (ack_b) begin
                if (prev >= 0 && i - prev != 3) gap_bad++;
                prev = i;
                nacks++;
            end
        end
        req_b = 1'b0;
        check("b2b ack_count", 32'(nacks), 32'd4);
        check("b2b ack_gap", 32'(gap_bad), 32'd0);
        check("b2b busy_cycles", 32'(nbusy), 32'd8);
        check("b2b addr_err", 32'(nerr), 32'd0);
        repeat (2) @(negedge clk);
        req_b = 1'b1; ren = 1'b1; wen = 1'b0; rwtype = 2'd2; addr = 32'h50;
        @(negedge clk);
        req_b = 1'b0; ren = 1'b0; wen = 1'b1; addr = 32'h54; wdata = 32'hFFFF_FFFF;
        found = 1'b0; rd = '0;
        for (int i = 0; i < 10; i++) begin
            if (ack_b) begin
                found = 1'b1; rd = rdata_b;
                break;
            end
            @(negedge clk);
        end
        check("w0 read ack_seen", 32'(found), 32'd1);
        check("w0 read rdata", rd, 32'h0000_0077);

        // Random traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            cnt = $urandom_range(0, 4);
            r = (cnt <= 1) || (cnt == 4);
            w = (cnt >= 2);
            t = 2'($urandom_range(0, 3));
            s = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + 32'($urandom_range(0, 15));
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 63));
            endcase
            mrd = $urandom;
            model_op(r, w, t, s, a, mrd, me, rd);
            begin
                logic [31:0] got;
                run_op(r, w, t, s, a, mrd, got, er, lat, bsy, ack_after);
                check($sformatf("rand%0d rdata a=%h t=%0d", i, a, t), got, rd);
                check($sformatf("rand%0d addr_err", i), 32'(er), 32'(me));
                check($sformatf("rand%0d latency", i), 32'(lat), 32'(WAITS + 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the CPU load/store interface (ren/wen/rwtype/addr/wdata/sign_extend in, rdata out).
- Adds a req/ack handshake, programmable wait states, byte/half/word lane handling, load extension and alignment/range error reporting.
- Intended as the data-memory target for the multi-cycle and pipelined cores; the storage array is internal.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the storage array (power of 2).
- WAIT_CYCLES, 2, extra wait-state cycles between request accept and ack (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active high
- req  input  1  request strobe, sampled only in IDLE
- ren  input  1  read request qualifier
- wen  input  1  write request qualifier
- rwtype  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- sign_extend  input  1  loads: 1 = sign-extend, 0 = zero-extend
- addr  input  32  byte address
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- busy  output  1  high while a request is in progress (WAIT or RESP)
- ack  output  1  one-cycle completion pulse
- rdata  output  32  load result, valid only while ack=1, else 0
- addr_err  output  1  one-cycle pulse coincident with ack for a rejected request

Behaviour:
- Reset (async): state=IDLE, busy=0, ack=0, rdata=0, addr_err=0, wait counter=0, captured request cleared. The storage array is not reset. A request in flight when reset asserts is aborted with no write.
- State machine IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: when req=1 and (ren|wen)=1, capture ren, wen, rwtype, sign_extend, addr and wdata, load counter=WAIT_CYCLES, go to WAIT. req=1 with ren=wen=0 is ignored.
  - WAIT: decrement the counter each cycle; go to RESP when the counter is 0. With WAIT_CYCLES=0, WAIT lasts one cycle.
  - RESP: perform the access, drive ack=1 for exactly this cycle, return to IDLE.
- Latency: request sampled at edge T; ack=1 in the cycle following edge T+1+WAIT_CYCLES. busy=1 from edge T through the ack cycle inclusive. A new req is accepted no earlier than the first IDLE cycle after ack.
- Input changes while busy have no effect; all operands come from the captured copy.
- Byte lanes are little-endian within a word: offset = addr[1:0], and offset 0 maps to bits [7:0].
  - word: whole word.
  - half: lanes {offset+1, offset}.
  - byte: lane offset.
- Store: in RESP, write only the addressed lanes of word index (addr-BASE_ADDR)>>2. Other lanes are unchanged.
- Load: in RESP, extract the lanes, right-justify, then zero- or sign-extend to 32 bits according to sign_extend. For word accesses, sign_extend is ignored.
- Error conditions, all causing addr_err=1 with ack, no write and rdata=0:
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - rwtype=11
  - ren=wen=1
  - addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS
- The range check uses full 32-bit unsigned comparison; there is no wrap-around aliasing.
- A write followed by a read of the same address returns the new data, since the write commits at the RESP edge.

Test Plan:
- Reset mid-WAIT: store request, assert rst during WAIT, release, then word-read the same address -> no ack during reset, and the prior value is unchanged (preload 32'hCAFE_F00D, read returns 32'hCAFE_F00D).
- Word timing, WAIT_CYCLES=2: word store 32'h1234_5678 @0x10, then word load @0x10 -> each ack is 4 cycles after the req edge, busy high for 4 cycles, rdata=32'h1234_5678.
- Byte merge: word store 32'hAABB_CCDD @0x20, byte store 8'h80 @0x21, then:
  - word load -> 32'hAABB_80DD
  - byte load @0x21 with sign_extend=1 -> 32'hFFFF_FF80
  - byte load @0x21 with sign_extend=0 -> 32'h0000_0080
- Half access: half store 16'h8001 @0x32, then:
  - half load with sign_extend=1 -> 32'hFFFF_8001
  - word load @0x30 -> upper half 16'h8001, lower half unchanged
- Errors:
  - word load @0x13 -> ack=1, addr_err=1, rdata=0
  - half store @0x31 -> addr_err=1, and the memory at 0x30 is unchanged
  - ren=wen=1 -> addr_err=1
  - addr=4*DEPTH_WORDS -> addr_err=1
- Back-to-back and ignored requests: req held high continuously with WAIT_CYCLES=0 -> ack every 3rd cycle; inputs changed mid-request are not used; req with ren=wen=0 -> no busy, no ack.
